// File: rtl/bp_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
// Defines the BTB entry layout, the direction counter and its update rule.
package bp_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX     = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = XLEN - IDX - 2;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic              valid;
    logic [TAG_W-1:0]  tag;
    logic [XLEN-1:0]   target;
    ctr_t              ctr;
  } btb_entry_t;

  localparam ctr_t CTR_RESET = WNT;
  localparam ctr_t CTR_ALLOC = WT;

  localparam btb_entry_t RESET_ENTRY = '{
    valid:  1'b0,
    tag:    '0,
    target: '0,
    ctr:    CTR_RESET
  };

  // Saturating step toward the resolved direction.
  function automatic ctr_t ctr_next(ctr_t c, logic taken);
    ctr_t n;
    n = c;
    if (taken) begin
      if (c != ST) n = ctr_t'(2'(c + 2'd1));
    end else begin
      if (c != SNT) n = ctr_t'(2'(c - 2'd1));
    end
    return n;
  endfunction

endpackage

// File: rtl/next_pc_predictor_if.sv
// Fetch/execute-facing signal bundle for the next-PC predictor.
// master drives PC and training info; slave (the predictor) returns the next PC.
interface next_pc_predictor_if;
  import bp_pkg::*;

  logic [XLEN-1:0] pc;
  logic            stall;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic [XLEN-1:0] pc_next;
  logic            hit;
  logic            pred_taken;

  modport master (
    output pc, stall, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_taken, upd_target,
    input  pc_next, hit, pred_taken
  );

  modport slave (
    input  pc, stall, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_taken, upd_target,
    output pc_next, hit, pred_taken
  );

endinterface

// File: rtl/btb_table.sv
// Direct-mapped BTB storage: combinational lookup port, combinational peek of
// the training index, and one synchronous write port. Reset clears every entry.
module btb_table
  import bp_pkg::*;
(
  input  logic             CLK,
  input  logic             reset,
  input  logic [IDX-1:0]   lk_idx,
  output btb_entry_t       lk_entry,
  input  logic [IDX-1:0]   wr_idx,
  output btb_entry_t       wr_cur,
  input  logic             wr_en,
  input  btb_entry_t       wr_entry
);

  btb_entry_t entries_q [ENTRIES];

  // Reset dominates any write presented in the same cycle.
  always_ff @(posedge CLK) begin
    if (reset) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        entries_q[i] <= RESET_ENTRY;
      end
    end else if (wr_en) begin
      entries_q[wr_idx] <= wr_entry;
    end
  end

  assign lk_entry = entries_q[lk_idx];
  assign wr_cur   = entries_q[wr_idx];

endmodule

// File: rtl/next_pc_predictor.sv
// Next-PC generator: BTB lookup on the current PC, priority selection of the
// next fetch address, and training from resolved execute-stage outcomes.
module next_pc_predictor
  import bp_pkg::*;
(
  input  logic               CLK,
  input  logic               reset,
  next_pc_predictor_if.slave bus
);

  logic [IDX-1:0]   lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX-1:0]   upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic [XLEN-1:0]  pc_plus4;

  btb_entry_t lk_entry;
  btb_entry_t upd_cur;
  btb_entry_t wr_entry;
  logic       wr_en;
  logic       lk_hit;
  logic       upd_hit;

  assign lk_idx   = bus.pc[IDX+1:2];
  assign lk_tag   = bus.pc[XLEN-1:IDX+2];
  assign upd_idx  = bus.upd_pc[IDX+1:2];
  assign upd_tag  = bus.upd_pc[XLEN-1:IDX+2];
  assign pc_plus4 = bus.pc + XLEN'(4);

  assign lk_hit  = lk_entry.valid && (lk_entry.tag == lk_tag);
  assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

  btb_table u_btb (
    .CLK      (CLK),
    .reset    (reset),
    .lk_idx   (lk_idx),
    .lk_entry (lk_entry),
    .wr_idx   (upd_idx),
    .wr_cur   (upd_cur),
    .wr_en    (wr_en),
    .wr_entry (wr_entry)
  );

  // Next fetch address: reset > redirect > stall > predicted target > pc+4.
  always_comb begin
    bus.hit        = 1'b0;
    bus.pred_taken = 1'b0;
    bus.pc_next    = pc_plus4;
    if (reset) begin
      bus.pc_next = '0;
    end else begin
      bus.hit        = lk_hit;
      bus.pred_taken = lk_hit && lk_entry.ctr[1];
      if (bus.redirect) begin
        bus.pc_next = bus.redirect_pc;
      end else if (bus.stall) begin
        bus.pc_next = bus.pc;
      end else if (lk_hit && lk_entry.ctr[1]) begin
        bus.pc_next = lk_entry.target;
      end
    end
  end

  // Training: hits move the counter, taken misses allocate, not-taken misses are dropped.
  always_comb begin
    wr_en    = 1'b0;
    wr_entry = upd_cur;
    if (bus.upd_valid) begin
      if (upd_hit) begin
        wr_en        = 1'b1;
        wr_entry.ctr = ctr_next(upd_cur.ctr, bus.upd_taken);
        if (bus.upd_taken) wr_entry.target = bus.upd_target;
      end else if (bus.upd_taken) begin
        wr_en    = 1'b1;
        wr_entry = '{
          valid:  1'b1,
          tag:    upd_tag,
          target: bus.upd_target,
          ctr:    CTR_ALLOC
        };
      end
    end
  end

endmodule
